// File: rtl/pool_pkg.sv
// Shared types and helpers for the max-pool sequencers (pool1, pool2).
// Default geometry matches the first pooling stage: 24x24 maps, 6 maps, 16-bit samples.
package pool_pkg;

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  localparam int DEF_IMG_W    = 24;
  localparam int DEF_NUM_MAPS = 6;
  localparam int DEF_DATA_W   = 16;

  // Wide enough for any sample width we pool; callers sign-extend into it.
  localparam int SMAX_W = 32;

  // On ties the first operand wins; the value is identical either way.
  function automatic logic signed [SMAX_W-1:0] smax(input logic signed [SMAX_W-1:0] a,
                                                    input logic signed [SMAX_W-1:0] b);
    return (b > a) ? b : a;
  endfunction

endpackage

// File: rtl/pool1_ctrl_if.sv
// Scheduler handshake plus conv1-read / pool1-write memory ports of the pool1 sequencer.
// master = sequencer side, slave = scheduler and memories.
interface pool1_ctrl_if import pool_pkg::*; #(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RD_ADDR_W = 12,
  parameter int WR_ADDR_W = 10
);
  logic                 start;
  logic                 busy;
  logic                 done;
  logic                 rd_en;
  logic [RD_ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0]    rd_data;
  logic                 wr_en;
  logic [WR_ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0]    wr_data;

  modport master (
    input  start, rd_data,
    output busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, rd_data,
    input  busy, done, rd_en, rd_addr, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/pool_win_addr.sv
// Window walker: tracks col/row/map of the current 2x2 window and its top-left read address.
// Advances in one cycle; base of the next window is valid the cycle after advance.
module pool_win_addr import pool_pkg::*; #(
  parameter int IMG_W     = DEF_IMG_W,
  parameter int NUM_MAPS  = DEF_NUM_MAPS,
  parameter int RD_ADDR_W = 12
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 advance,
  input  logic                 clear,
  output logic [RD_ADDR_W-1:0] base,
  output logic                 last_window
);
  localparam int HALF = IMG_W / 2;
  localparam int CW   = $clog2(HALF + 1);
  localparam int MW   = $clog2(NUM_MAPS + 1);

  localparam logic [CW-1:0]        POS_LAST = CW'(HALF - 1);
  localparam logic [MW-1:0]        MAP_LAST = MW'(NUM_MAPS - 1);
  localparam logic [RD_ADDR_W-1:0] STEP_COL = RD_ADDR_W'(2);
  // Skips the odd row; from the last window of a map it lands on the next map's origin.
  localparam logic [RD_ADDR_W-1:0] STEP_ROW = RD_ADDR_W'(IMG_W + 2);

  logic [CW-1:0] col;
  logic [CW-1:0] row;
  logic [MW-1:0] map;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      base <= '0;
      col  <= '0;
      row  <= '0;
      map  <= '0;
    end else if (clear) begin
      base <= '0;
      col  <= '0;
      row  <= '0;
      map  <= '0;
    end else if (advance) begin
      if (col != POS_LAST) begin
        base <= base + STEP_COL;
        col  <= col + CW'(1);
      end else begin
        base <= base + STEP_ROW;
        col  <= '0;
        if (row != POS_LAST) begin
          row <= row + CW'(1);
        end else begin
          row <= '0;
          map <= map + MW'(1);
        end
      end
    end
  end

  assign last_window = (col == POS_LAST) && (row == POS_LAST) && (map == MAP_LAST);

endmodule

// File: rtl/pool1_ctrl.sv
// 2x2 signed max-pool sequencer: 4 reads + 1 write per window, start -> first read next cycle.
// No memory backpressure: read data must return exactly one cycle after rd_en.
module pool1_ctrl import pool_pkg::*; #(
  parameter int IMG_W     = DEF_IMG_W,
  parameter int NUM_MAPS  = DEF_NUM_MAPS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int RD_ADDR_W = 12,
  parameter int WR_ADDR_W = 10
) (
  input  logic         clk,
  input  logic         reset,
  pool1_ctrl_if.master bus
);
  localparam logic [RD_ADDR_W-1:0] OFF_ROW = RD_ADDR_W'(IMG_W);

  state_t                  state;
  logic [1:0]              phase;
  logic                    busy_q;
  logic                    done_q;
  logic                    rd_en_q;
  logic                    wr_en_q;
  logic [RD_ADDR_W-1:0]    rd_addr_q;
  logic [WR_ADDR_W-1:0]    wr_addr_q;
  logic [WR_ADDR_W-1:0]    out_addr;
  logic signed [DATA_W-1:0] max_q;
  logic signed [DATA_W-1:0] sample;
  logic signed [DATA_W-1:0] pick;
  logic [RD_ADDR_W-1:0]    base;
  logic                    last_window;
  logic                    advance;
  logic                    clear;

  // Tap offset inside the window: {0, 1, W, W+1}.
  function automatic logic [RD_ADDR_W-1:0] tap(input logic [1:0] p);
    return (p[1] ? OFF_ROW : '0) + {{(RD_ADDR_W-1){1'b0}}, p[0]};
  endfunction

  assign sample  = bus.rd_data;
  assign pick    = DATA_W'(smax(SMAX_W'(max_q), SMAX_W'(sample)));
  assign clear   = (state == IDLE) && bus.start;
  // The last tap address is already issued, so the walker can move on a cycle early.
  assign advance = (state == RD) && (phase == 2'd3);

  pool_win_addr #(
    .IMG_W    (IMG_W),
    .NUM_MAPS (NUM_MAPS),
    .RD_ADDR_W(RD_ADDR_W)
  ) u_win (
    .clk        (clk),
    .reset      (reset),
    .advance    (advance),
    .clear      (clear),
    .base       (base),
    .last_window(last_window)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      phase     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      wr_en_q   <= 1'b0;
      rd_addr_q <= '0;
      wr_addr_q <= '0;
      out_addr  <= '0;
      max_q     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= RD;
            phase     <= '0;
            busy_q    <= 1'b1;
            rd_en_q   <= 1'b1;
            rd_addr_q <= '0;
            out_addr  <= '0;
          end
        end
        RD: begin
          // rd_data here belongs to the previous phase's read.
          if (phase == 2'd1) begin
            max_q <= sample;
          end else if (phase != 2'd0) begin
            max_q <= pick;
          end
          if (phase == 2'd3) begin
            state     <= WR;
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b1;
            wr_addr_q <= out_addr;
            done_q    <= last_window;
          end else begin
            phase     <= phase + 2'd1;
            rd_addr_q <= base + tap(phase + 2'd1);
          end
        end
        WR: begin
          wr_en_q  <= 1'b0;
          done_q   <= 1'b0;
          out_addr <= out_addr + WR_ADDR_W'(1);
          if (done_q) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else begin
            state     <= RD;
            phase     <= '0;
            rd_en_q   <= 1'b1;
            rd_addr_q <= base;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.rd_en   = rd_en_q;
  assign bus.rd_addr = rd_addr_q;
  assign bus.wr_en   = wr_en_q;
  assign bus.wr_addr = wr_addr_q;
  // Fourth sample arrives during WR, so the final max is folded in combinationally.
  assign bus.wr_data = wr_en_q ? pick : '0;

endmodule

// File: tb/tb_pool1_ctrl.sv
// Bench for pool1_ctrl: a 4x4 single-map instance and a 24x24 two-map instance,
// checked against a window-by-window reference computed from the memory contents.
module tb_pool1_ctrl;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  pool1_ctrl_if #(.DATA_W(16), .RD_ADDR_W(12), .WR_ADDR_W(10)) bs ();
  pool1_ctrl_if #(.DATA_W(16), .RD_ADDR_W(12), .WR_ADDR_W(10)) bl ();

  pool1_ctrl #(.IMG_W(4), .NUM_MAPS(1), .DATA_W(16), .RD_ADDR_W(12), .WR_ADDR_W(10)) dut_s (
    .clk  (clk),
    .reset(reset),
    .bus  (bs)
  );

  pool1_ctrl #(.IMG_W(24), .NUM_MAPS(2), .DATA_W(16), .RD_ADDR_W(12), .WR_ADDR_W(10)) dut_l (
    .clk  (clk),
    .reset(reset),
    .bus  (bl)
  );

  logic [15:0] mem_s [16];
  logic [15:0] mem_l [1152];

  // Synchronous-read RAMs, one cycle latency.
  always @(posedge clk) if (bs.rd_en) bs.rd_data <= mem_s[int'(bs.rd_addr) % 16];
  always @(posedge clk) if (bl.rd_en) bl.rd_data <= mem_l[int'(bl.rd_addr) % 1152];

  ev_t rd_s[$], wr_s[$], rd_l[$], wr_l[$];
  int  dn_s[$], dn_l[$];

  always @(negedge clk) begin
    if (bs.rd_en) rd_s.push_back('{cyc, int'(bs.rd_addr), 0});
    if (bs.wr_en) wr_s.push_back('{cyc, int'(bs.wr_addr), int'(bs.wr_data)});
    if (bs.done)  dn_s.push_back(cyc);
    if (bl.rd_en) rd_l.push_back('{cyc, int'(bl.rd_addr), 0});
    if (bl.wr_en) wr_l.push_back('{cyc, int'(bl.wr_addr), int'(bl.wr_data)});
    if (bl.done)  dn_l.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic clear_q();
    rd_s.delete(); wr_s.delete(); dn_s.delete();
    rd_l.delete(); wr_l.delete(); dn_l.delete();
  endtask

  task automatic launch(input int which, output int n0);
    if (which == 0) bs.start = 1'b1; else bl.start = 1'b1;
    n0 = cyc;
    step();
    bs.start = 1'b0;
    bl.start = 1'b0;
  endtask

  function automatic logic [15:0] mem_at(input int which, input int a);
    return (which == 0) ? mem_s[a % 16] : mem_l[a % 1152];
  endfunction

  function automatic logic [15:0] rnd16();
    case ($urandom_range(0, 5))
      0: return 16'h8000;
      1: return 16'h7FFF;
      2: return 16'hFFFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic chk_zero(input int which, input string nm);
    if (which == 0) begin
      chk({nm, " busy"}, 32'(bs.busy), 0);
      chk({nm, " done"}, 32'(bs.done), 0);
      chk({nm, " rd_en"}, 32'(bs.rd_en), 0);
      chk({nm, " wr_en"}, 32'(bs.wr_en), 0);
      chk({nm, " rd_addr"}, 32'(bs.rd_addr), 0);
      chk({nm, " wr_addr"}, 32'(bs.wr_addr), 0);
      chk({nm, " wr_data"}, 32'(bs.wr_data), 0);
    end else begin
      chk({nm, " busy"}, 32'(bl.busy), 0);
      chk({nm, " done"}, 32'(bl.done), 0);
      chk({nm, " rd_en"}, 32'(bl.rd_en), 0);
      chk({nm, " wr_en"}, 32'(bl.wr_en), 0);
      chk({nm, " rd_addr"}, 32'(bl.rd_addr), 0);
      chk({nm, " wr_addr"}, 32'(bl.wr_addr), 0);
      chk({nm, " wr_data"}, 32'(bl.wr_data), 0);
    end
  endtask

  // Reference: every window of every map, row-major, 4 reads then 1 write, 5 cycles each.
  task automatic compare_run(input int which, input int n0, input int w, input int maps,
                             input string nm);
    ev_t rq[$], wq[$];
    int  dq[$];
    int  hw, nwin, k, base, a, sv, mx;
    if (which == 0) begin rq = rd_s; wq = wr_s; dq = dn_s; end
    else            begin rq = rd_l; wq = wr_l; dq = dn_l; end
    hw   = w / 2;
    nwin = maps * hw * hw;
    chk({nm, " reads"}, rq.size(), 4 * nwin);
    chk({nm, " writes"}, wq.size(), nwin);
    chk({nm, " dones"}, dq.size(), 1);
    if (dq.size() > 0) chk({nm, " done cyc"}, dq[0], n0 + 5 * nwin);
    k = 0;
    mx = 0;
    for (int m = 0; m < maps; m++) begin
      for (int r = 0; r < hw; r++) begin
        for (int c = 0; c < hw; c++) begin
          base = m * w * w + 2 * r * w + 2 * c;
          for (int p = 0; p < 4; p++) begin
            a  = base + (p / 2) * w + (p % 2);
            sv = int'($signed(mem_at(which, a)));
            mx = (p == 0 || sv > mx) ? sv : mx;
            if (4 * k + p < rq.size()) begin
              chk($sformatf("%s rd%0d addr", nm, 4 * k + p), rq[4 * k + p].addr, a);
              chk($sformatf("%s rd%0d cyc", nm, 4 * k + p), rq[4 * k + p].cyc, n0 + 1 + 5 * k + p);
            end
          end
          if (k < wq.size()) begin
            chk($sformatf("%s wr%0d addr", nm, k), wq[k].addr, k);
            chk($sformatf("%s wr%0d data", nm, k), wq[k].data, mx & 32'hFFFF);
            chk($sformatf("%s wr%0d cyc", nm, k), wq[k].cyc, n0 + 5 + 5 * k);
          end
          k++;
        end
      end
    end
  endtask

  int n0, n1;

  initial begin
    bs.start = 1'b0;
    bl.start = 1'b0;
    for (int i = 0; i < 16; i++) mem_s[i] = 16'h0;
    for (int i = 0; i < 1152; i++) mem_l[i] = 16'h0;

    // Reset and idle
    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    clear_q();
    repeat (10) step();
    @(negedge clk);
    chk_zero(0, "idle_s");
    chk_zero(1, "idle_l");
    chk("idle events", rd_s.size() + wr_s.size() + rd_l.size() + wr_l.size(), 0);
    step();

    // Ramp 0..15 on the 4x4 map
    for (int i = 0; i < 16; i++) mem_s[i] = 16'(i);
    clear_q();
    launch(0, n0);
    @(negedge clk);
    chk("ramp busy T+1", 32'(bs.busy), 1);
    chk("ramp rd_en T+1", 32'(bs.rd_en), 1);
    chk("ramp rd_addr T+1", 32'(bs.rd_addr), 0);
    goto(n0 + 21);
    @(negedge clk);
    chk("ramp busy after done", 32'(bs.busy), 0);
    step();
    compare_run(0, n0, 4, 1, "ramp");
    if (wr_s.size() == 4) begin
      chk("ramp w1 data", wr_s[1].data, 7);
      chk("ramp w3 data", wr_s[3].data, 15);
    end

    // Signed windows: negatives and all-minimum
    for (int i = 0; i < 16; i++) mem_s[i] = rnd16();
    mem_s[0] = 16'hFFFD; mem_s[1] = 16'hFFFF; mem_s[4] = 16'hFFF8; mem_s[5] = 16'hFFFE;
    mem_s[2] = 16'h8000; mem_s[3] = 16'h8000; mem_s[6] = 16'h8000; mem_s[7] = 16'h8000;
    clear_q();
    launch(0, n0);
    goto(n0 + 22);
    compare_run(0, n0, 4, 1, "signed");
    if (wr_s.size() >= 2) begin
      chk("signed neg max", wr_s[0].data, 32'hFFFF);
      chk("signed min max", wr_s[1].data, 32'h8000);
    end

    // Random data, extremes and ties weighted in
    for (int t = 0; t < 4; t++) begin
      for (int i = 0; i < 16; i++) mem_s[i] = rnd16();
      clear_q();
      launch(0, n0);
      goto(n0 + 22);
      compare_run(0, n0, 4, 1, $sformatf("rnd%0d", t));
    end

    // start mid-run is ignored; start held through done restarts in the following cycle
    for (int i = 0; i < 16; i++) mem_s[i] = rnd16();
    clear_q();
    launch(0, n0);
    goto(n0 + 7);
    bs.start = 1'b1;
    step();
    bs.start = 1'b0;
    goto(n0 + 15);
    bs.start = 1'b1;
    goto(n0 + 22);
    bs.start = 1'b0;
    compare_run(0, n0, 4, 1, "run1");
    clear_q();
    n1 = n0 + 21;
    goto(n1 + 22);
    compare_run(0, n1, 4, 1, "run2");

    // Full-size geometry, two maps
    for (int i = 0; i < 1152; i++) mem_l[i] = rnd16();
    clear_q();
    launch(1, n0);
    goto(n0 + 1445);
    compare_run(1, n0, 24, 2, "big");
    if (rd_l.size() >= 580 && wr_l.size() > 144) begin
      chk("big w144 rd0", rd_l[576].addr, 576);
      chk("big w144 rd2", rd_l[578].addr, 600);
      chk("big w144 rd3", rd_l[579].addr, 601);
      chk("big w144 wr_addr", wr_l[144].addr, 144);
    end
    if (dn_l.size() > 0) chk("big done latency", dn_l[0] - n0, 1440);

    // Reset in window 5, phase 2
    for (int i = 0; i < 1152; i++) mem_l[i] = rnd16();
    clear_q();
    launch(1, n0);
    goto(n0 + 28);
    reset = 1'b1;
    @(negedge clk);
    chk_zero(1, "midreset");
    repeat (3) step();
    chk("midreset reads", rd_l.size(), 22);
    chk("midreset writes", wr_l.size(), 5);
    reset = 1'b0;
    step();
    @(negedge clk);
    chk_zero(1, "post reset");
    step();
    clear_q();
    launch(1, n0);
    goto(n0 + 1445);
    compare_run(1, n0, 24, 2, "rerun");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
